// File: rtl/ch1_sweep_freq.sv
// rtl/ch1_sweep_freq.sv - channel 1 frequency register, sweep shadow/adder and period counter
module ch1_sweep_freq #(
    parameter int FREQ_W = 11
) (
    input  logic              phi,
    input  logic              apu_reset,
    input  logic [7:0]        d,
    input  logic              apu_wr,
    input  logic              ff13,
    input  logic              ff14,
    input  logic              ff10_neg,
    input  logic              ch1_restart,
    input  logic              ch1_ld_shift,
    input  logic              ch1_shift_clk,
    input  logic              ch1_freq_upd1,
    input  logic              ch1_freq_upd2,
    input  logic              tick_en,
    output logic [FREQ_W-1:0] ch1_freq,
    output logic              ch1_freq_tick,
    output logic              ch1_sweep_ovf
);

    localparam logic [FREQ_W-1:0] CNT_MAX = {FREQ_W{1'b1}};
    localparam logic [FREQ_W-1:0] CNT_ONE = {{(FREQ_W-1){1'b0}}, 1'b1};

    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] freq_next;
    logic [FREQ_W-1:0] shadow;
    logic [FREQ_W-1:0] cnt;
    logic [FREQ_W:0]   sum;
    logic              ovf_cond;
    logic              tick;
    logic              ovf;

    // The carry out only means overflow when adding; subtraction wraps.
    always_comb begin
        sum       = ff10_neg ? ({1'b0, freq} - {1'b0, shadow})
                             : ({1'b0, freq} + {1'b0, shadow});
        ovf_cond  = !ff10_neg && sum[FREQ_W];
        freq_next = freq;
        if (apu_wr && (ff13 || ff14)) begin
            if (ff13) freq_next[7:0] = d;
            if (ff14) freq_next[FREQ_W-1:8] = d[FREQ_W-9:0];
        end else if (ch1_freq_upd1 && !ovf_cond) begin
            freq_next = sum[FREQ_W-1:0];
        end
    end

    always_ff @(posedge phi) begin
        if (apu_reset) begin
            freq   <= '0;
            shadow <= '0;
            cnt    <= '0;
            tick   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            freq <= freq_next;

            if (ch1_ld_shift)       shadow <= freq;
            else if (ch1_shift_clk) shadow <= shadow >> 1;

            if (ch1_restart)        ovf <= 1'b0;
            else if (ch1_freq_upd2 && ovf_cond) ovf <= 1'b1;

            // Restart reloads with the freshly written frequency and suppresses the tick.
            tick <= 1'b0;
            if (ch1_restart) begin
                cnt <= freq_next;
            end else if (tick_en) begin
                if (cnt == CNT_MAX) begin
                    cnt  <= freq;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign ch1_freq      = freq;
    assign ch1_freq_tick = tick;
    assign ch1_sweep_ovf = ovf;

endmodule

// File: tb/tb_ch1_sweep_freq.sv
// tb/tb_ch1_sweep_freq.sv - directed and random checks of ch1_sweep_freq against a pulse-count model
module tb_ch1_sweep_freq;

    logic        phi = 1'b0;
    logic        apu_reset, apu_wr, ff13, ff14, ff10_neg, ch1_restart;
    logic        ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2, tick_en;
    logic [7:0]  d;
    logic [10:0] ch1_freq;
    logic        ch1_freq_tick, ch1_sweep_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int ticks;

    // Model: the period counter is tracked as "tick_en pulses left until the next wrap".
    int m_freq, m_shadow, m_ovf, m_tick, m_rem;

    always #5 phi = ~phi;

    ch1_sweep_freq #(.FREQ_W(11)) dut (
        .phi(phi), .apu_reset(apu_reset), .d(d), .apu_wr(apu_wr), .ff13(ff13), .ff14(ff14),
        .ff10_neg(ff10_neg), .ch1_restart(ch1_restart), .ch1_ld_shift(ch1_ld_shift),
        .ch1_shift_clk(ch1_shift_clk), .ch1_freq_upd1(ch1_freq_upd1),
        .ch1_freq_upd2(ch1_freq_upd2), .tick_en(tick_en), .ch1_freq(ch1_freq),
        .ch1_freq_tick(ch1_freq_tick), .ch1_sweep_ovf(ch1_sweep_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int nf, s, oc, new_freq;
        if (apu_reset) begin
            m_freq = 0; m_shadow = 0; m_ovf = 0; m_tick = 0; m_rem = 2048;
            return;
        end
        if (ff10_neg) begin
            nf = (m_freq - m_shadow) & 'h7FF;
            oc = 0;
        end else begin
            s  = m_freq + m_shadow;
            oc = (s > 2047);
            nf = s & 'h7FF;
        end
        new_freq = m_freq;
        if (apu_wr && (ff13 || ff14)) begin
            if (ff13) new_freq = (new_freq & 'h700) | d;
            if (ff14) new_freq = (new_freq & 'h0FF) | ((d & 7) << 8);
        end else if (ch1_freq_upd1 && !oc) begin
            new_freq = nf;
        end
        if (ch1_ld_shift)       m_shadow = m_freq;
        else if (ch1_shift_clk) m_shadow = m_shadow / 2;
        if (ch1_restart)        m_ovf = 0;
        else if (ch1_freq_upd2 && oc) m_ovf = 1;
        m_tick = 0;
        if (ch1_restart) begin
            m_rem = 2048 - new_freq;
        end else if (tick_en) begin
            m_rem--;
            if (m_rem == 0) begin
                m_tick = 1;
                m_rem  = 2048 - m_freq;
            end
        end
        m_freq = new_freq;
    endtask

    task automatic clear_in();
        apu_reset = 0; apu_wr = 0; ff13 = 0; ff14 = 0; d = 0; ch1_restart = 0;
        ch1_ld_shift = 0; ch1_shift_clk = 0; ch1_freq_upd1 = 0; ch1_freq_upd2 = 0; tick_en = 0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge phi);
        #1;
        chk("freq", 32'(ch1_freq), 32'(m_freq));
        chk("tick", 32'(ch1_freq_tick), 32'(m_tick));
        chk("ovf", 32'(ch1_sweep_ovf), 32'(m_ovf));
        if (ch1_freq_tick) ticks++;
        clear_in();
    endtask

    task automatic wr_freq(input int v);
        apu_wr = 1; ff13 = 1; d = 8'(v); cyc();
        apu_wr = 1; ff14 = 1; d = 8'(v >> 8); cyc();
    endtask

    initial begin
        clear_in();
        ff10_neg = 0;
        m_freq = 0; m_shadow = 0; m_ovf = 0; m_tick = 0; m_rem = 2048;
        #2;
        apu_reset = 1; cyc();
        chk("reset_freq", 32'(ch1_freq), 0);
        chk("reset_ovf", 32'(ch1_sweep_ovf), 0);

        apu_wr = 1; ff13 = 1; d = 8'h34; cyc();
        apu_wr = 1; ff14 = 1; d = 8'h05; cyc();
        chk("wr_534", 32'(ch1_freq), 32'h534);
        ch1_restart = 1; cyc();
        for (int i = 0; i < 5; i++) begin tick_en = 1; cyc(); end
        apu_reset = 1; tick_en = 1; cyc();
        chk("midrst_freq", 32'(ch1_freq), 0);
        chk("midrst_tick", 32'(ch1_freq_tick), 0);

        wr_freq('h7FC);
        ch1_restart = 1; cyc();
        ticks = 0;
        for (int i = 0; i < 40; i++) begin tick_en = (i % 4 == 3); cyc(); end
        chk("tick_count_7fc", 32'(ticks), 2);

        ff10_neg = 0;
        wr_freq('h100);
        ch1_ld_shift = 1; cyc();
        ch1_shift_clk = 1; cyc();
        ch1_freq_upd1 = 1; cyc();
        chk("sweep_180", 32'(ch1_freq), 32'h180);
        ch1_ld_shift = 1; cyc();
        ch1_shift_clk = 1; cyc();
        ch1_freq_upd1 = 1; cyc();
        chk("sweep_240", 32'(ch1_freq), 32'h240);

        wr_freq('h700);
        ch1_ld_shift = 1; cyc();
        ch1_freq_upd2 = 1; cyc();
        chk("ovf_set", 32'(ch1_sweep_ovf), 1);
        ch1_freq_upd1 = 1; cyc();
        chk("ovf_hold_freq", 32'(ch1_freq), 32'h700);
        ch1_restart = 1; cyc();
        chk("ovf_clr", 32'(ch1_sweep_ovf), 0);

        ff10_neg = 1;
        wr_freq('h010);
        ch1_ld_shift = 1; cyc();
        ch1_freq_upd1 = 1; cyc();
        chk("neg_zero", 32'(ch1_freq), 0);
        chk("neg_no_ovf", 32'(ch1_sweep_ovf), 0);
        wr_freq('h002);
        ch1_ld_shift = 1; cyc();
        wr_freq('h001);
        ch1_freq_upd1 = 1; ch1_freq_upd2 = 1; cyc();
        chk("neg_wrap", 32'(ch1_freq), 32'h7FF);
        chk("neg_wrap_ovf", 32'(ch1_sweep_ovf), 0);

        ff10_neg = 0;
        wr_freq('h123);
        ch1_ld_shift = 1; cyc();
        apu_wr = 1; ff13 = 1; d = 8'hAA; ch1_freq_upd1 = 1; cyc();
        chk("wr_beats_upd1", 32'(ch1_freq), 32'h1AA);
        wr_freq('h700);
        ch1_ld_shift = 1; cyc();
        ch1_freq_upd2 = 1; cyc();
        chk("ovf_again", 32'(ch1_sweep_ovf), 1);
        ch1_restart = 1; ch1_freq_upd2 = 1; cyc();
        chk("restart_beats_upd2", 32'(ch1_sweep_ovf), 0);

        for (int i = 0; i < 4000; i++) begin
            apu_reset     = ($urandom_range(0, 299) == 0);
            apu_wr        = ($urandom_range(0, 15) == 0);
            ff13          = $urandom_range(0, 1);
            ff14          = $urandom_range(0, 1);
            d             = 8'($urandom);
            ff10_neg      = ($urandom_range(0, 3) == 0);
            ch1_restart   = ($urandom_range(0, 63) == 0);
            ch1_ld_shift  = ($urandom_range(0, 7) == 0);
            ch1_shift_clk = ($urandom_range(0, 3) == 0);
            ch1_freq_upd1 = ($urandom_range(0, 7) == 0);
            ch1_freq_upd2 = ($urandom_range(0, 7) == 0);
            tick_en       = ($urandom_range(0, 1) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ch1_sweep_freq.md
Name: ch1_sweep_freq

Overview:
- Channel 1 frequency path: holds the 11-bit frequency (FF13 plus FF14[2:0]), the sweep shadow shift register, the add/subtract unit and the 11-bit period counter.
- Consumes the sweep control strobes from the channel 1 control block: ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1 and ch1_freq_upd2.
- Produces the duty-step tick that clocks the channel 1 duty sequencer, plus the sweep overflow flag that kills the channel.
- Fully synchronous: all strobes are sampled as clock-enables on phi.

Parameters:
- FREQ_W, 11, width of frequency register, shadow register and period counter.

Ports:
- phi  input  1  APU clock; all state updates on its rising edge.
- apu_reset  input  1  reset; synchronous and active-high.
- d  input  8  CPU data bus.
- apu_wr  input  1  CPU write strobe, one phi cycle wide.
- ff13  input  1  register select for FF13 (frequency low byte).
- ff14  input  1  register select for FF14 (frequency high bits and trigger).
- ff10_neg  input  1  sweep direction; 1 subtracts, 0 adds.
- ch1_restart  input  1  channel trigger pulse, one cycle wide.
- ch1_ld_shift  input  1  level; while high, the shadow register loads the frequency.
- ch1_shift_clk  input  1  one-cycle enable; shifts the shadow register right by 1.
- ch1_freq_upd1  input  1  one-cycle enable; commit the sweep sum to the frequency register.
- ch1_freq_upd2  input  1  one-cycle enable; evaluate overflow.
- tick_en  input  1  period-counter enable (1 MHz rate), one cycle wide.
- ch1_freq  output  FREQ_W  current frequency register.
- ch1_freq_tick  output  1  one-cycle pulse on period-counter wrap, to the duty sequencer.
- ch1_sweep_ovf  output  1  sticky sweep overflow; the channel disables while it is high.

Behaviour:

Reset (apu_reset high at a phi edge):
- freq = 0, shadow = 0, period counter = 0.
- ch1_freq_tick = 0, ch1_sweep_ovf = 0.
- Reset overrides every other event in the same cycle.

Frequency register:
- apu_wr & ff13 sets freq[7:0] = d.
- apu_wr & ff14 sets freq[10:8] = d[2:0]; d[7:3] are ignored here.
- Both writes take effect on the next edge.
- A CPU write beats ch1_freq_upd1 in the same cycle, and the sweep commit is dropped.

Shadow register:
- ch1_ld_shift high: shadow = freq. This has priority over ch1_shift_clk.
- Otherwise, ch1_shift_clk: shadow = shadow >> 1, with zero fill.
- Loading freq=0 yields shadow 0, and shifting stays at 0.

Sum (combinational, 12 bits):
- sum = {0,freq} + {0,shadow} when ff10_neg = 0.
- sum = {0,freq} - {0,shadow} when ff10_neg = 1; wrap is modulo 2^12, and sum[11] is ignored for subtraction.
- ovf_cond = !ff10_neg & sum[11].

ch1_freq_upd1:
- If !ovf_cond: freq = sum[10:0].
- If ovf_cond: freq is unchanged.
- Subtraction never sets ovf_cond; underflow wraps into the 11 bits.

ch1_freq_upd2:
- If ovf_cond: ch1_sweep_ovf = 1 on the next edge.
- It stays high until ch1_restart or reset.

ch1_restart:
- Clears ch1_sweep_ovf.
- Loads the period counter with freq; if freq is written in the same cycle, the new value is used.
- Does not pulse ch1_freq_tick.
- Restart wins over a simultaneous ch1_freq_upd2.

Period counter:
- Up-counts on tick_en.
- When the counter is 0x7FF and tick_en is high: counter = freq and ch1_freq_tick = 1 for exactly that following cycle.
- Period = 2048 − freq tick_en pulses; freq = 0x7FF gives a tick on every tick_en.
- Frequency writes do not disturb the running count; they take effect at the next wrap or restart.
- Restart and wrap in the same cycle: restart wins and there is no tick.

Latency:
- All outputs are registered, one phi cycle after the causing input.

Test Plan:
- Reset, then write FF13=0x34 and FF14=0x05 → ch1_freq=0x534 one cycle later. Assert apu_reset mid-count → ch1_freq=0, no tick, ovf=0.
- freq=0x7FC, restart, tick_en every 4th cycle → first ch1_freq_tick after 4 tick_en pulses, then every 4 thereafter, each pulse exactly 1 cycle.
- freq=0x100, add, ld_shift then 1 shift_clk, upd1 → ch1_freq=0x180. A second ld/shift/upd1 sequence → 0x240.
- freq=0x700, add, ld_shift with no shift, upd2 → ch1_sweep_ovf=1. Then upd1 → freq stays 0x700. Then ch1_restart → ovf=0.
- freq=0x010, negate, ld_shift with no shift, upd1 → freq=0x000 and ovf stays 0. Repeat with freq=0x001 and shadow=0x002 → freq=0x7FF, no overflow.
- CPU write FF13=0xAA in the same cycle as upd1 → freq[7:0]=0xAA and the sweep sum is discarded. Restart together with upd2 while ovf_cond=1 → ovf=0.
